// File: rtl/comparator_track.sv
// Streaming W-bit magnitude comparator with a registered result, running min/max of `a`
// and a debounced "a above b" flag. Signedness is fixed at elaboration by SIGNED.
module comparator_track #(
    parameter int W        = 8,
    parameter bit SIGNED   = 1'b0,
    parameter int DEBOUNCE = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         ceq,
    output logic         clt,
    output logic         cgt,
    output logic [W-1:0] amin,
    output logic [W-1:0] amax,
    output logic         mm_valid,
    output logic         hi
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {LO, UP, HI, DN} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           out_valid_q, out_valid_d;
    logic           ceq_q, ceq_d;
    logic           clt_q, clt_d;
    logic           cgt_q, cgt_d;
    logic [W-1:0]   amin_q, amin_d;
    logic [W-1:0]   amax_q, amax_d;
    logic           mm_valid_q, mm_valid_d;

    logic           accept;
    logic           a_gt_b, a_lt_b, a_lt_min, a_gt_max;
    logic signed [W:0] a_x, b_x, amin_x, amax_x;

    // One extra top bit lets a single signed compare serve both modes:
    // it carries the sign in SIGNED mode and is zero otherwise.
    assign a_x    = $signed({SIGNED ? a[W-1]      : 1'b0, a});
    assign b_x    = $signed({SIGNED ? b[W-1]      : 1'b0, b});
    assign amin_x = $signed({SIGNED ? amin_q[W-1] : 1'b0, amin_q});
    assign amax_x = $signed({SIGNED ? amax_q[W-1] : 1'b0, amax_q});

    assign a_gt_b   = a_x > b_x;
    assign a_lt_b   = a_x < b_x;
    assign a_lt_min = a_x < amin_x;
    assign a_gt_max = a_x > amax_x;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Result register: refills on accept, drains when consumed.
    always_comb begin
        out_valid_d = out_valid_q;
        ceq_d       = ceq_q;
        clt_d       = clt_q;
        cgt_d       = cgt_q;
        if (accept) begin
            out_valid_d = 1'b1;
            ceq_d       = !a_gt_b && !a_lt_b;
            clt_d       = a_lt_b;
            cgt_d       = a_gt_b;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Min/max tracking; clr discards a coincident sample.
    always_comb begin
        amin_d     = amin_q;
        amax_d     = amax_q;
        mm_valid_d = mm_valid_q;
        if (clr) begin
            amin_d     = '0;
            amax_d     = '0;
            mm_valid_d = 1'b0;
        end else if (accept) begin
            if (!mm_valid_q) begin
                amin_d     = a;
                amax_d     = a;
                mm_valid_d = 1'b1;
            end else begin
                if (a_lt_min) amin_d = a;
                if (a_gt_max) amax_d = a;
            end
        end
    end

    // Debounce: UP/DN count consecutive samples against the current level.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clr) begin
            state_d = LO;
            cnt_d   = '0;
        end else if (accept) begin
            case (state_q)
                LO: begin
                    if (a_gt_b) begin
                        cnt_d   = CNT_ONE;
                        state_d = (DEBOUNCE == 1) ? HI : UP;
                    end
                end
                UP: begin
                    if (a_gt_b) begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (cnt_q + CNT_ONE == CNT_MAX) state_d = HI;
                    end else begin
                        cnt_d   = '0;
                        state_d = LO;
                    end
                end
                HI: begin
                    if (!a_gt_b) begin
                        cnt_d   = CNT_ONE;
                        state_d = (DEBOUNCE == 1) ? LO : DN;
                    end
                end
                DN: begin
                    if (!a_gt_b) begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (cnt_q + CNT_ONE == CNT_MAX) state_d = LO;
                    end else begin
                        cnt_d   = '0;
                        state_d = HI;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = LO;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LO;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            ceq_q       <= 1'b0;
            clt_q       <= 1'b0;
            cgt_q       <= 1'b0;
            amin_q      <= '0;
            amax_q      <= '0;
            mm_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            ceq_q       <= ceq_d;
            clt_q       <= clt_d;
            cgt_q       <= cgt_d;
            amin_q      <= amin_d;
            amax_q      <= amax_d;
            mm_valid_q  <= mm_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign ceq       = ceq_q;
    assign clt       = clt_q;
    assign cgt       = cgt_q;
    assign amin      = amin_q;
    assign amax      = amax_q;
    assign mm_valid  = mm_valid_q;
    assign hi        = (state_q == HI) || (state_q == DN);

endmodule

// File: tb/tb_comparator_track.sv
// Bench for comparator_track: three instances (unsigned D=3, signed D=3, unsigned D=1)
// share one stimulus stream and are checked against a behavioural model.
module tb_comparator_track;

    logic       clk = 1'b0;
    logic       rst, clr, in_valid, out_ready;
    logic [7:0] a, b;

    logic       ir[3], ov[3], eq[3], lt[3], gt[3], mmv[3], hi[3];
    logic [7:0] mn[3], mx[3];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        comparator_track #(
            .W(8), .SIGNED(k == 1), .DEBOUNCE((k == 2) ? 1 : 3)
        ) u_dut (
            .clk(clk), .rst(rst), .clr(clr),
            .in_valid(in_valid), .in_ready(ir[k]),
            .a(a), .b(b),
            .out_valid(ov[k]), .out_ready(out_ready),
            .ceq(eq[k]), .clt(lt[k]), .cgt(gt[k]),
            .amin(mn[k]), .amax(mx[k]), .mm_valid(mmv[k]), .hi(hi[k])
        );
    end

    // Reference model: integer compares, and hi flips once the last D accepted
    // samples all disagree with the current level.
    bit          m_ov;
    bit          m_eq[3], m_lt[3], m_gt[3], m_mmv[3], m_hi[3];
    logic [7:0]  m_mn[3], m_mx[3];
    int unsigned hist[3];
    int          hn[3];

    function automatic bit sgk(input int k); return k == 1; endfunction
    function automatic int dbk(input int k); return (k == 2) ? 1 : 3; endfunction
    function automatic int val(input logic [7:0] x, input bit s);
        return s ? int'($signed(x)) : int'({24'd0, x});
    endfunction

    function automatic logic [21:0] got(input int k);
        return {ov[k], eq[k], lt[k], gt[k], mmv[k], hi[k], mn[k], mx[k]};
    endfunction
    function automatic logic [21:0] exp_v(input int k);
        return {m_ov, m_eq[k], m_lt[k], m_gt[k], m_mmv[k], m_hi[k], m_mn[k], m_mx[k]};
    endfunction

    task automatic drive(input bit v, input logic [7:0] av, input logic [7:0] bv,
                         input bit ordy, input bit c, input bit r);
        in_valid = v; a = av; b = bv; out_ready = ordy; clr = c; rst = r;
        #1;
    endtask

    task automatic tick();
        bit acc;
        @(posedge clk);
        acc = in_valid && (!m_ov || out_ready);
        if (rst) begin
            m_ov = 0;
            for (int k = 0; k < 3; k++) begin
                m_eq[k] = 0; m_lt[k] = 0; m_gt[k] = 0; m_mmv[k] = 0; m_hi[k] = 0;
                m_mn[k] = 0; m_mx[k] = 0; hist[k] = 0; hn[k] = 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                int av, bv, d;
                int unsigned mask;
                av = val(a, sgk(k)); bv = val(b, sgk(k)); d = dbk(k);
                mask = (32'd1 << d) - 1;
                if (acc) begin
                    m_eq[k] = (av == bv); m_lt[k] = (av < bv); m_gt[k] = (av > bv);
                end
                if (clr) begin
                    m_mmv[k] = 0; m_mn[k] = 0; m_mx[k] = 0; m_hi[k] = 0; hist[k] = 0; hn[k] = 0;
                end else if (acc) begin
                    if (!m_mmv[k]) begin
                        m_mn[k] = a; m_mx[k] = a; m_mmv[k] = 1;
                    end else begin
                        if (av < val(m_mn[k], sgk(k))) m_mn[k] = a;
                        if (av > val(m_mx[k], sgk(k))) m_mx[k] = a;
                    end
                    hist[k] = (hist[k] << 1) | ((av > bv) ? 1 : 0);
                    hn[k]++;
                    if (hn[k] >= d) begin
                        if (!m_hi[k] && (hist[k] & mask) == mask) m_hi[k] = 1;
                        else if (m_hi[k] && (hist[k] & mask) == 0) m_hi[k] = 0;
                    end
                end
            end
            if (acc) m_ov = 1;
            else if (out_ready) m_ov = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        drive(0, 8'd0, 8'd0, 1, 0, 1);
        tick();
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (got(k) !== 22'd0 || ir[k] !== 1'b1) begin
                n_err++;
                $display("FAIL reset k=%0d got %h ir=%b exp 0 ir=1", k, got(k), ir[k]);
            end
        end
    endtask

    task automatic test_basic();
        logic [7:0] av[3] = '{8'd5, 8'd3, 8'd200};
        logic [7:0] bv[3] = '{8'd5, 8'd9, 8'd7};
        logic [2:0] ex[3] = '{3'b100, 3'b010, 3'b001};
        for (int i = 0; i < 3; i++) begin
            drive(1, av[i], bv[i], 1, 0, 0);
            tick();
            n_chk++;
            if ({ov[0], eq[0], lt[0], gt[0]} !== {1'b1, ex[i]}) begin
                n_err++;
                $display("FAIL basic_const i=%0d got %b exp %b", i, {ov[0], eq[0], lt[0], gt[0]}, {1'b1, ex[i]});
            end
            for (int k = 0; k < 3; k++) begin
                n_chk++;
                if (got(k) !== exp_v(k)) begin
                    n_err++;
                    $display("FAIL basic k=%0d i=%0d got %h exp %h", k, i, got(k), exp_v(k));
                end
            end
        end
    endtask

    task automatic test_signed();
        drive(1, 8'hF0, 8'h05, 1, 1, 0);
        tick();
        n_chk++;
        if (lt[1] !== 1'b1 || gt[0] !== 1'b1) begin
            n_err++;
            $display("FAIL signed_cmp got s.lt=%b u.gt=%b exp 1 1", lt[1], gt[0]);
        end
        drive(1, 8'h10, 8'h00, 1, 0, 0);
        tick();
        drive(1, 8'hF0, 8'h00, 1, 0, 0);
        tick();
        n_chk++;
        if (mn[1] !== 8'hF0 || mx[1] !== 8'h10 || mn[0] !== 8'h10 || mx[0] !== 8'hF0) begin
            n_err++;
            $display("FAIL signed_minmax got s=%h/%h u=%h/%h exp f0/10 10/f0", mn[1], mx[1], mn[0], mx[0]);
        end
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (got(k) !== exp_v(k)) begin
                n_err++;
                $display("FAIL signed k=%0d got %h exp %h", k, got(k), exp_v(k));
            end
        end
    endtask

    task automatic test_backpressure();
        drive(1, 8'd1, 8'd2, 1, 0, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1, 8'd9, 8'd4, 0, 0, 0);
            n_chk++;
            if (ir[0] !== 1'b0) begin
                n_err++;
                $display("FAIL bp_ready i=%0d got %b exp 0", i, ir[0]);
            end
            tick();
            n_chk++;
            if ({ov[0], lt[0], gt[0]} !== 3'b110 || got(0) !== exp_v(0)) begin
                n_err++;
                $display("FAIL bp_hold i=%0d got %h exp %h", i, got(0), exp_v(0));
            end
        end
        drive(1, 8'd9, 8'd4, 1, 0, 0);
        n_chk++;
        if (ir[0] !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release_ready got %b exp 1", ir[0]);
        end
        tick();
        n_chk++;
        if ({ov[0], lt[0], gt[0]} !== 3'b101) begin
            n_err++;
            $display("FAIL bp_release got %b exp 101", {ov[0], lt[0], gt[0]});
        end
        drive(1, 8'd4, 8'd9, 1, 0, 0);
        tick();
        n_chk++;
        if ({ov[0], lt[0], gt[0]} !== 3'b110) begin
            n_err++;
            $display("FAIL bp_next got %b exp 110", {ov[0], lt[0], gt[0]});
        end
        drive(0, 8'd0, 8'd0, 1, 0, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (got(k) !== exp_v(k) || ov[k] !== 1'b0) begin
                n_err++;
                $display("FAIL bp_drain k=%0d got %h exp %h", k, got(k), exp_v(k));
            end
        end
    endtask

    task automatic test_debounce();
        bit s[12]  = '{1, 1, 0, 1, 1, 1, 0, 0, 1, 0, 0, 0};
        bit eh[12] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0};
        drive(0, 8'd0, 8'd0, 1, 1, 0);
        tick();
        for (int i = 0; i < 12; i++) begin
            if (s[i]) drive(1, 8'd20, 8'd10, 1, 0, 0);
            else if (i == 6) drive(1, 8'd15, 8'd15, 1, 0, 0);
            else drive(1, 8'd10, 8'd20, 1, 0, 0);
            tick();
            n_chk++;
            if (hi[0] !== eh[i] || hi[1] !== eh[i]) begin
                n_err++;
                $display("FAIL debounce i=%0d got %b%b exp %b", i, hi[0], hi[1], eh[i]);
            end
            n_chk++;
            if (got(2) !== exp_v(2)) begin
                n_err++;
                $display("FAIL debounce_d1 i=%0d got %h exp %h", i, got(2), exp_v(2));
            end
        end
    endtask

    task automatic test_minmax_clr();
        logic [7:0] av[3] = '{8'd40, 8'd10, 8'd90};
        drive(0, 8'd0, 8'd0, 1, 1, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, av[i], 8'd0, 1, 0, 0);
            tick();
        end
        n_chk++;
        if (mn[0] !== 8'd10 || mx[0] !== 8'd90 || mmv[0] !== 1'b1) begin
            n_err++;
            $display("FAIL minmax got %0d/%0d v=%b exp 10/90 v=1", mn[0], mx[0], mmv[0]);
        end
        drive(1, 8'd50, 8'd0, 1, 1, 0);
        tick();
        n_chk++;
        if (mmv[0] !== 1'b0 || mn[0] !== 8'd0 || {ov[0], gt[0]} !== 2'b11) begin
            n_err++;
            $display("FAIL clr_accept got v=%b mn=%0d ov=%b gt=%b exp 0 0 1 1", mmv[0], mn[0], ov[0], gt[0]);
        end
        drive(1, 8'd60, 8'd70, 1, 0, 0);
        tick();
        n_chk++;
        if (mn[0] !== 8'd60 || mx[0] !== 8'd60 || mmv[0] !== 1'b1) begin
            n_err++;
            $display("FAIL after_clr got %0d/%0d v=%b exp 60/60 v=1", mn[0], mx[0], mmv[0]);
        end
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (got(k) !== exp_v(k)) begin
                n_err++;
                $display("FAIL minmax_model k=%0d got %h exp %h", k, got(k), exp_v(k));
            end
        end
    endtask

    task automatic test_reset_mid();
        bit eh[3] = '{0, 0, 1};
        drive(0, 8'd0, 8'd0, 1, 1, 0);
        tick();
        drive(1, 8'd5, 8'd1, 0, 0, 0);
        tick();
        drive(1, 8'd5, 8'd1, 0, 0, 1);
        tick();
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (got(k) !== 22'd0) begin
                n_err++;
                $display("FAIL reset_mid k=%0d got %h exp 0", k, got(k));
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'd5, 8'd1, 1, 0, 0);
            tick();
            n_chk++;
            if (hi[0] !== eh[i]) begin
                n_err++;
                $display("FAIL reset_recount i=%0d got %b exp %b", i, hi[0], eh[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [7:0] av, bv;
            bit v, ordy, c;
            av   = 8'($urandom);
            bv   = ($urandom_range(0, 4) == 0) ? av : 8'($urandom);
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 9) < 7);
            c    = ($urandom_range(0, 39) == 0);
            drive(v, av, bv, ordy, c, 0);
            n_chk++;
            if (ir[0] !== (!m_ov || ordy)) begin
                n_err++;
                $display("FAIL rand_ready i=%0d got %b exp %b", i, ir[0], !m_ov || ordy);
            end
            tick();
            for (int k = 0; k < 3; k++) begin
                n_chk++;
                if (got(k) !== exp_v(k)) begin
                    n_err++;
                    $display("FAIL random k=%0d i=%0d got %h exp %h", k, i, got(k), exp_v(k));
                end
            end
        end
    endtask

    initial begin
        rst = 1; clr = 0; in_valid = 0; out_ready = 1; a = 0; b = 0;
        m_ov = 0;
        test_reset();
        test_basic();
        test_signed();
        test_backpressure();
        test_debounce();
        test_minmax_clr();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
